// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed 7-segment debug display scanner.
package seg_scan_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_7seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Multi-page multiplexed 7-segment scanner with dead time, frame-aligned paging and blanking.
// Optional leading-zero blanking enabled by defining SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_display
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned NUM_PAGES   = 4,
    parameter int unsigned SCAN_DIV    = 40000,
    parameter int unsigned DEAD_CYCLES = 0,
    parameter int unsigned PAGE_W      = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PAGE_W-1:0]                 page_sel,
    input  logic                              blank,
    input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] data_in,
    output logic [6:0]                        seg,
    output logic [NUM_DIGITS-1:0]             select,
    output logic                              frame_tick
);

    localparam int unsigned WORD_W  = NUM_DIGITS * 4;
    localparam int unsigned CNT_MAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam bit          HAS_DEAD = (DEAD_CYCLES > 0);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(HAS_DEAD ? DEAD_CYCLES - 1 : 0);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DIG_W-1:0]      r_digit;
    logic [DIG_W-1:0]      w_digit_nxt;
    logic [PAGE_W-1:0]     r_page_q;
    logic [PAGE_W-1:0]     w_page_req;
    logic [PAGE_W-1:0]     w_page;
    logic                  w_boundary;
    logic [WORD_W-1:0]     w_word;
    logic [3:0]            w_nibble;
    logic                  w_show;
    logic [6:0]            w_seg_dec;
    logic [6:0]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_select_nxt;
    logic                  w_tick_nxt;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic                  w_seen;
`endif

    // Frame starts at the first cycle of digit 0's slot (its dead gap when one exists).
    assign w_boundary = (r_digit == '0) && (r_cnt == '0) &&
                        (HAS_DEAD ? (r_state == DEAD) : (r_state == ON));
    assign w_page_req = (32'(page_sel) < NUM_PAGES) ? page_sel : '0;
    assign w_page     = w_boundary ? w_page_req : r_page_q;

    always_comb begin
        w_word = '0;
        for (int p = 0; p < NUM_PAGES; p++) begin
            if (w_page == PAGE_W'(p)) begin
                w_word = data_in[p*WORD_W +: WORD_W];
            end
        end
    end

    // Digit 0 is the most significant nibble; leading zeros optionally suppressed.
    always_comb begin
        w_nibble = 4'h0;
        w_show   = 1'b1;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        w_seen   = 1'b0;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            w_seen = w_seen | (w_word[(NUM_DIGITS-i)*4-1 -: 4] != 4'h0);
`endif
            if (r_digit == DIG_W'(i)) begin
                w_nibble = w_word[(NUM_DIGITS-i)*4-1 -: 4];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
                w_show   = w_seen | (i == int'(NUM_DIGITS) - 1);
`endif
            end
        end
    end

    hex_to_7seg u_dec (
        .i_nibble (w_nibble),
        .o_seg_c  (w_seg_dec)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_digit_nxt  = r_digit;
        w_tick_nxt   = w_boundary;
        w_seg_nxt    = SEG_OFF;
        w_select_nxt = '1;

        case (r_state)
            DEAD: begin
                if (!HAS_DEAD || (r_cnt == DEAD_LAST)) begin
                    w_state_nxt = ON;
                    w_cnt_nxt   = '0;
                end
            end
            ON: begin
                if (r_cnt == SCAN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_digit_nxt = (r_digit == DIG_LAST) ? '0 : r_digit + DIG_W'(1);
                    w_state_nxt = HAS_DEAD ? DEAD : ON;
                end
            end
            default: begin
                w_state_nxt = DEAD;
                w_cnt_nxt   = '0;
            end
        endcase

        // Blank only gates the drive; the scan keeps its phase.
        if ((r_state == ON) && !blank && w_show) begin
            w_seg_nxt = w_seg_dec;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                w_select_nxt[i] = (r_digit != DIG_W'(NUM_DIGITS - 1 - i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= DEAD;
            r_cnt      <= '0;
            r_digit    <= '0;
            r_page_q   <= '0;
            seg        <= SEG_OFF;
            select     <= '1;
            frame_tick <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_digit    <= w_digit_nxt;
            r_page_q   <= w_page;
            seg        <= w_seg_nxt;
            select     <= w_select_nxt;
            frame_tick <= w_tick_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: scan order, paging, out-of-range page, blank, async reset, zero-dead-time scan.
module tb_seg_scan_display;

    logic        clk;
    logic        rst_n;
    logic        blank;
    logic [1:0]  page_sel;
    logic [1:0]  page_sel3;
    logic [1:0]  page_sel_z;
    logic [63:0] data_in;
    logic [47:0] data3;
    logic [63:0] data_za;
    logic [63:0] data_zb;
    logic [6:0]  seg, seg3, seg_za, seg_zb;
    logic [3:0]  select, select3, select_za, select_zb;
    logic        frame_tick, tick3, tick_za, tick_zb;

    int          k;
    int          n_checks;
    int          n_pass;
    logic [15:0] w_main;
    logic [15:0] w3;
    logic [6:0]  lut [16];
    logic [6:0]  exp_lz_a [4];
    logic [6:0]  exp_lz_b [4];

    seg_scan_display #(.NUM_DIGITS(4), .NUM_PAGES(4), .SCAN_DIV(4), .DEAD_CYCLES(1), .PAGE_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .page_sel(page_sel), .blank(blank), .data_in(data_in),
        .seg(seg), .select(select), .frame_tick(frame_tick));

    seg_scan_display #(.NUM_DIGITS(4), .NUM_PAGES(3), .SCAN_DIV(4), .DEAD_CYCLES(1), .PAGE_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .page_sel(page_sel3), .blank(blank), .data_in(data3),
        .seg(seg3), .select(select3), .frame_tick(tick3));

    seg_scan_display #(.NUM_DIGITS(4), .NUM_PAGES(4), .SCAN_DIV(4), .DEAD_CYCLES(0), .PAGE_W(2)) u_dut_za (
        .clk(clk), .rst_n(rst_n), .page_sel(page_sel_z), .blank(blank), .data_in(data_za),
        .seg(seg_za), .select(select_za), .frame_tick(tick_za));

    seg_scan_display #(.NUM_DIGITS(4), .NUM_PAGES(4), .SCAN_DIV(4), .DEAD_CYCLES(0), .PAGE_W(2)) u_dut_zb (
        .clk(clk), .rst_n(rst_n), .page_sel(page_sel_z), .blank(blank), .data_in(data_zb),
        .seg(seg_zb), .select(select_zb), .frame_tick(tick_zb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    endtask

    task automatic check_reset();
        check("rst_seg",    32'(seg),        32'h7F);
        check("rst_sel",    32'(select),     32'hF);
        check("rst_tick",   32'(frame_tick), 32'h0);
        check("rst3_seg",   32'(seg3),       32'h7F);
        check("rst3_sel",   32'(select3),    32'hF);
        check("rstz_seg",   32'(seg_za),     32'h7F);
        check("rstz_sel",   32'(select_za),  32'hF);
        check("rstz_tick",  32'(tick_za),    32'h0);
    endtask

    // Expected outputs after edge k, given blank as seen at that edge.
    task automatic check_all(input logic b);
        int         ph, slot, pos;
        logic       on;
        logic [3:0] nib;
        logic [6:0] se, se_a, se_b;
        logic [3:0] sl, sl_a, sl_b;
        logic       tk;

        ph   = (k - 1) % 20;
        slot = ph / 5;
        pos  = ph % 5;
        on   = (pos != 0) && !b;
        nib  = 4'(w_main >> ((3 - slot) * 4));
        se   = on ? lut[nib] : 7'h7F;
        sl   = on ? ~(4'b1000 >> slot) : 4'hF;
        check("main_seg",  32'(seg),        32'(se));
        check("main_sel",  32'(select),     32'(sl));
        check("main_tick", 32'(frame_tick), 32'(ph == 0));

        nib = 4'(w3 >> ((3 - slot) * 4));
        se  = on ? lut[nib] : 7'h7F;
        check("oor_seg", 32'(seg3),    32'(se));
        check("oor_sel", 32'(select3), 32'(sl));

        if (k == 1) begin
            slot = 0;
            tk   = 1'b0;
            se_a = 7'h7F;
            se_b = 7'h7F;
        end else begin
            ph   = (k - 2) % 16;
            slot = ph / 4;
            tk   = (ph == 0);
            se_a = b ? 7'h7F : exp_lz_a[slot];
            se_b = b ? 7'h7F : exp_lz_b[slot];
        end
        sl_a = (se_a == 7'h7F) ? 4'hF : ~(4'b1000 >> slot);
        sl_b = (se_b == 7'h7F) ? 4'hF : ~(4'b1000 >> slot);
        check("z0050_seg",  32'(seg_za),    32'(se_a));
        check("z0050_sel",  32'(select_za), 32'(sl_a));
        check("z0050_tick", 32'(tick_za),   32'(tk));
        check("z0000_seg",  32'(seg_zb),    32'(se_b));
        check("z0000_sel",  32'(select_zb), 32'(sl_b));
    endtask

    task automatic run_cycle();
        logic b;
        b = blank;
        @(posedge clk);
        k++;
        @(negedge clk);
        check_all(b);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        k          = 0;
        rst_n      = 1'b0;
        blank      = 1'b0;
        page_sel   = 2'd0;
        page_sel3  = 2'd3;
        page_sel_z = 2'd0;
        data_in    = {16'h9E0F, 16'hABCD, 16'h5A5A, 16'h1234};
        data3      = {16'h1111, 16'hEEEE, 16'h5678};
        data_za    = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0050};
        data_zb    = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
        w_main     = 16'h1234;
        w3         = 16'h5678;
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        exp_lz_a = '{7'h7F, 7'h7F, 7'h12, 7'h40};
        exp_lz_b = '{7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
        exp_lz_a = '{7'h40, 7'h40, 7'h12, 7'h40};
        exp_lz_b = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif

        #8;
        check_reset();
        #4 rst_n = 1'b1;

        // Frame 1: page 0; page 2 requested during digit 1 must not show until next frame.
        for (int i = 0; i < 20; i++) begin
            run_cycle();
            if (k == 7) page_sel = 2'd2;
        end

        // Frame 2: page 2.
        w_main = 16'hABCD;
        for (int i = 0; i < 20; i++) run_cycle();

        // Frames 3-4: blank for 7 edges spanning a frame boundary.
        for (int i = 0; i < 40; i++) begin
            blank = (k + 1 >= 58) && (k + 1 <= 64);
            run_cycle();
        end
        blank = 1'b0;

        // Into digit 2 of frame 5, then async reset between edges.
        for (int i = 0; i < 12; i++) run_cycle();
        #2 rst_n = 1'b0;
        #1 check_reset();
        #1 rst_n = 1'b1;
        k = 0;

        // Scan restarts with a frame boundary.
        for (int i = 0; i < 21; i++) run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
